// File: rtl/bpu_update_queue_pkg.sv
// Shared types and constants for the branch-resolution update queue.
// Provides the queued entry layout, the BTB update class encoding,
// the delay-slot fall-through offset and the head classifier.
package bpu_update_queue_pkg;

  localparam int          PC_W                 = 32;
  localparam logic [31:0] PC_DELAY_SLOT_OFFSET = 32'd8;

  // One resolved control-flow instruction waiting to train the BTB.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            uncond;
    logic            real_taken;
    logic [PC_W-1:0] real_addr;
  } upd_entry_t;

  localparam int ENTRY_W = $bits(upd_entry_t);

  typedef enum logic [1:0] {
    CLS_NONE      = 2'd0,
    CLS_UNCOND    = 2'd1,
    CLS_TAKEN     = 2'd2,
    CLS_NOT_TAKEN = 2'd3
  } upd_class_e;

  function automatic upd_class_e classify(input logic vld, input upd_entry_t e);
    if (!vld)              return CLS_NONE;
    else if (e.uncond)     return CLS_UNCOND;
    else if (e.real_taken) return CLS_TAKEN;
    else                   return CLS_NOT_TAKEN;
  endfunction

endpackage

// File: rtl/bpu_update_queue_fifo.sv
// sync_fifo: single-clock FIFO with wrapping pointers and occupancy count.
// Ports: clk, reset (sync, active-high), push/din, pop/dout (head, always
// visible), full, empty, count (0..DEPTH). Push while full and pop while
// empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset: the count gates everything read from it.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bpu_update_queue.sv
// bpu_update_queue: buffers resolved branches from EX and feeds them one per
// unstalled cycle to the BTB update port; raises a registered one-cycle
// redirect on mispredict and counts branches / mispredicts.
// Ports: ex_* capture side (ex_ready = !full), stallreq freezes the head,
// update_*/pred_*/real_* head presentation (zero when empty),
// redirect_valid/redirect_pc, br_count/mis_count.
module bpu_update_queue
  import bpu_update_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_pc,
  input  logic        ex_uncond,
  input  logic        ex_btb_hit,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_addr,
  input  logic        ex_real_taken,
  input  logic [31:0] ex_real_addr,
  input  logic        stallreq,
  output logic        update_valid,
  output logic [31:0] update_pc,
  output logic        pred_flag,
  output logic        pred_true,
  output logic        real_direct,
  output logic [31:0] real_address,
  output logic        update_type,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mis_count
);
  localparam int CW = $clog2(DEPTH+1);

  logic          full, empty, accept, push, pop;
  logic          rtaken, mispredict, filtered;
  logic [31:0]   target;
  logic [CW-1:0] occupancy;
  upd_entry_t    din, head;
  upd_class_e    cls;

  assign ex_ready = !full;
  assign accept   = ex_valid && !full;

  // Jumps always resolve taken regardless of what EX reports.
  assign rtaken     = ex_uncond | ex_real_taken;
  assign mispredict = (rtaken != ex_pred_taken) ||
                      (rtaken && ex_pred_taken && (ex_real_addr != ex_pred_addr));
  // A not-taken branch that missed the BTB has no entry to train.
  assign filtered   = !ex_uncond && !rtaken && !ex_btb_hit;
  assign target     = rtaken ? ex_real_addr : ex_pc + PC_DELAY_SLOT_OFFSET;

  assign push = accept && !filtered;
  assign pop  = !empty && !stallreq;
  assign din  = '{pc: ex_pc, uncond: ex_uncond, real_taken: rtaken, real_addr: ex_real_addr};

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  assign update_valid = (occupancy != '0);
  assign cls          = classify(update_valid, head);
  assign pred_flag    = (cls == CLS_UNCOND) || (cls == CLS_NOT_TAKEN);
  assign pred_true    = (cls == CLS_TAKEN);
  assign update_type  = (cls == CLS_UNCOND);
  assign real_direct  = update_valid && head.real_taken;
  assign update_pc    = update_valid ? head.pc : '0;
  assign real_address = update_valid ? head.real_addr : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      br_count       <= '0;
      mis_count      <= '0;
    end else begin
      redirect_valid <= accept && mispredict;
      if (accept && mispredict) begin
        redirect_pc <= target;
        mis_count   <= mis_count + 32'd1;
      end
      if (accept) br_count <= br_count + 32'd1;
    end
  end

endmodule
